// File: rtl/car_flow_counter.sv
// Car sensor front end: synchronizer, debounce, one pulse per car, 4-digit BCD running total,
// and a per-window car count latched once every WINDOW_S one-second ticks.
module car_flow_counter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int WINDOW_S        = 60,
    parameter int RATE_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_1s,
    input  logic              car_in,
    input  logic              clr,
    output logic              car_pulse,
    output logic [15:0]       total_bcd,
    output logic [7:0]        sec_cnt,
    output logic [RATE_W-1:0] rate,
    output logic              rate_valid
);

    // state | meaning
    // COUNT | accumulating cars and ticks for the current window
    // CLOSE | one cycle: publish win_cnt as rate, start the next window
    typedef enum logic {
        COUNT,
        CLOSE
    } state_t;

    localparam int                DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]        SEC_LAST = 8'(WINDOW_S - 1);
    localparam logic [RATE_W-1:0] WIN_MAX  = '1;

    state_t            state;
    state_t            state_nxt;
    logic              s1;
    logic              s2;
    logic              car_db;
    logic [DB_W-1:0]   db_cnt;
    logic [RATE_W-1:0] win_cnt;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Only s2 is used downstream; car_in is asynchronous to clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            car_db    <= 1'b0;
            db_cnt    <= '0;
            car_pulse <= 1'b0;
        end else begin
            s1        <= car_in;
            s2        <= s1;
            car_pulse <= 1'b0;
            if (s2 == car_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                car_db    <= s2;
                db_cnt    <= '0;
                car_pulse <= s2;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_bcd <= 16'h0000;
        end else if (clr) begin
            total_bcd <= 16'h0000;
        end else if (car_pulse) begin
            total_bcd <= bcd_inc(total_bcd);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COUNT:   if (clk_1s && sec_cnt == SEC_LAST) state_nxt = CLOSE;
            CLOSE:   state_nxt = COUNT;
            default: state_nxt = COUNT;
        endcase
    end

    // A car arriving during CLOSE seeds the new window's count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_cnt    <= 8'd0;
            win_cnt    <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            case (state)
                COUNT: begin
                    if (car_pulse && win_cnt != WIN_MAX) begin
                        win_cnt <= win_cnt + RATE_W'(1);
                    end
                    if (clk_1s && sec_cnt != SEC_LAST) begin
                        sec_cnt <= sec_cnt + 8'd1;
                    end
                end
                CLOSE: begin
                    rate       <= win_cnt;
                    rate_valid <= 1'b1;
                    win_cnt    <= {{(RATE_W-1){1'b0}}, car_pulse};
                    sec_cnt    <= 8'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_car_flow_counter.sv
// Directed bench for car_flow_counter; a second instance with a short debounce
// walks the BCD total through its full 0000..9999 range in reasonable time.
module tb_car_flow_counter;

    localparam int D  = 4;
    localparam int W  = 3;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_1s;
    logic          car_in;
    logic          clr;
    logic          car_pulse;
    logic [15:0]   total_bcd;
    logic [7:0]    sec_cnt;
    logic [RW-1:0] rate;
    logic          rate_valid;

    logic          tick2;
    logic          car_in2;
    logic          clr2;
    logic          car_pulse2;
    logic [15:0]   total2;
    logic [7:0]    sec_cnt2;
    logic [RW-1:0] rate2;
    logic          rate_valid2;

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    car_flow_counter #(.DEBOUNCE_CYCLES(D), .WINDOW_S(W), .RATE_W(RW)) dut (
        .clk(clk), .rst(rst), .clk_1s(clk_1s), .car_in(car_in), .clr(clr),
        .car_pulse(car_pulse), .total_bcd(total_bcd), .sec_cnt(sec_cnt),
        .rate(rate), .rate_valid(rate_valid)
    );

    car_flow_counter #(.DEBOUNCE_CYCLES(2), .WINDOW_S(W), .RATE_W(RW)) dut_wrap (
        .clk(clk), .rst(rst), .clk_1s(tick2), .car_in(car_in2), .clr(clr2),
        .car_pulse(car_pulse2), .total_bcd(total2), .sec_cnt(sec_cnt2),
        .rate(rate2), .rate_valid(rate_valid2)
    );

    task automatic reset_dut();
        rst     = 1'b1;
        clk_1s  = 1'b0;
        car_in  = 1'b0;
        clr     = 1'b0;
        tick2   = 1'b0;
        car_in2 = 1'b0;
        clr2    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic car(input int hi, input int lo);
        car_in = 1'b1;
        repeat (hi) @(negedge clk);
        car_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic car2();
        car_in2 = 1'b1;
        repeat (2) @(negedge clk);
        car_in2 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic tick_gap();
        clk_1s = 1'b1;
        @(negedge clk);
        clk_1s = 1'b0;
        repeat (19) @(negedge clk);
    endtask

    // Closing tick: returns at the negedge after edge t+1 (rate_valid high).
    task automatic close_window();
        clk_1s = 1'b1;
        @(negedge clk);
        clk_1s = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_dut();
        check_cnt++; if (car_pulse !== 1'b0) $display("FAIL reset_car_pulse: got %b expected 0", car_pulse); else pass_cnt++;
        check_cnt++; if (total_bcd !== 16'h0000) $display("FAIL reset_total: got %h expected 0000", total_bcd); else pass_cnt++;
        check_cnt++; if (sec_cnt !== 8'd0) $display("FAIL reset_sec_cnt: got %0d expected 0", sec_cnt); else pass_cnt++;
        check_cnt++; if (rate !== 4'd0) $display("FAIL reset_rate: got %0d expected 0", rate); else pass_cnt++;
        check_cnt++; if (rate_valid !== 1'b0) $display("FAIL reset_rate_valid: got %b expected 0", rate_valid); else pass_cnt++;
        check_cnt++; if (total2 !== 16'h0000) $display("FAIL reset_total_wrap: got %h expected 0000", total2); else pass_cnt++;
    endtask

    task automatic test_clean_car();
        int pulses;
        int at;
        int fall_pulses;
        pulses = 0;
        at = -1;
        fall_pulses = 0;
        car_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (car_pulse === 1'b1) begin
                pulses++;
                at = i;
            end
            if (i == 5) begin
                check_cnt++; if (total_bcd !== 16'h0000) $display("FAIL clean_total_early: got %h expected 0000", total_bcd); else pass_cnt++;
            end
            if (i == 6) begin
                check_cnt++; if (total_bcd !== 16'h0001) $display("FAIL clean_total: got %h expected 0001", total_bcd); else pass_cnt++;
            end
        end
        car_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (car_pulse === 1'b1) fall_pulses++;
        end
        check_cnt++; if (pulses !== 1) $display("FAIL clean_pulse_count: got %0d expected 1", pulses); else pass_cnt++;
        check_cnt++; if (at !== 5) $display("FAIL clean_pulse_latency: got %0d expected 5", at); else pass_cnt++;
        check_cnt++; if (fall_pulses !== 0) $display("FAIL clean_fall_pulse: got %0d expected 0", fall_pulses); else pass_cnt++;
    endtask

    task automatic test_bounce();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            car_in = (i % 2 == 0);
            @(negedge clk);
            if (car_pulse === 1'b1) pulses++;
        end
        car_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (car_pulse === 1'b1) pulses++;
        end
        car_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (car_pulse === 1'b1) pulses++;
        end
        check_cnt++; if (pulses !== 1) $display("FAIL bounce_pulse_count: got %0d expected 1", pulses); else pass_cnt++;
        check_cnt++; if (total_bcd !== 16'h0002) $display("FAIL bounce_total: got %h expected 0002", total_bcd); else pass_cnt++;

        pulses = 0;
        car_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (car_pulse === 1'b1) pulses++;
        end
        car_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (car_pulse === 1'b1) pulses++;
        end
        check_cnt++; if (pulses !== 0) $display("FAIL glitch_pulse_count: got %0d expected 0", pulses); else pass_cnt++;
        check_cnt++; if (total_bcd !== 16'h0002) $display("FAIL glitch_total: got %h expected 0002", total_bcd); else pass_cnt++;
    endtask

    task automatic test_clr_collision();
        car_in = 1'b1;
        repeat (6) @(negedge clk);
        check_cnt++; if (car_pulse !== 1'b1) $display("FAIL clr_pulse_present: got %b expected 1", car_pulse); else pass_cnt++;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_cnt++; if (total_bcd !== 16'h0000) $display("FAIL clr_total: got %h expected 0000", total_bcd); else pass_cnt++;
        car_in = 1'b0;
        repeat (8) @(negedge clk);
        check_cnt++; if (total_bcd !== 16'h0000) $display("FAIL clr_total_after: got %h expected 0000", total_bcd); else pass_cnt++;
    endtask

    task automatic test_bcd_wrap();
        repeat (99) car2();
        repeat (2) @(negedge clk);
        check_cnt++; if (total2 !== 16'h0099) $display("FAIL bcd_0099: got %h expected 0099", total2); else pass_cnt++;
        car2();
        repeat (2) @(negedge clk);
        check_cnt++; if (total2 !== 16'h0100) $display("FAIL bcd_0100: got %h expected 0100", total2); else pass_cnt++;
        repeat (1134) car2();
        repeat (2) @(negedge clk);
        check_cnt++; if (total2 !== 16'h1234) $display("FAIL bcd_1234: got %h expected 1234", total2); else pass_cnt++;
        repeat (8765) car2();
        repeat (2) @(negedge clk);
        check_cnt++; if (total2 !== 16'h9999) $display("FAIL bcd_9999: got %h expected 9999", total2); else pass_cnt++;
        car2();
        repeat (2) @(negedge clk);
        check_cnt++; if (total2 !== 16'h0000) $display("FAIL bcd_wrap: got %h expected 0000", total2); else pass_cnt++;
    endtask

    task automatic test_window();
        reset_dut();
        repeat (5) car(6, 6);
        tick_gap();
        tick_gap();
        check_cnt++; if (sec_cnt !== 8'd2) $display("FAIL window_sec_cnt: got %0d expected 2", sec_cnt); else pass_cnt++;
        clk_1s = 1'b1;
        @(negedge clk);
        clk_1s = 1'b0;
        check_cnt++; if (rate_valid !== 1'b0) $display("FAIL window_valid_early: got %b expected 0", rate_valid); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (rate_valid !== 1'b1) $display("FAIL window_valid: got %b expected 1", rate_valid); else pass_cnt++;
        check_cnt++; if (rate !== 4'd5) $display("FAIL window_rate: got %0d expected 5", rate); else pass_cnt++;
        check_cnt++; if (sec_cnt !== 8'd0) $display("FAIL window_sec_wrap: got %0d expected 0", sec_cnt); else pass_cnt++;
        check_cnt++; if (total_bcd !== 16'h0005) $display("FAIL window_total: got %h expected 0005", total_bcd); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (rate_valid !== 1'b0) $display("FAIL window_valid_width: got %b expected 0", rate_valid); else pass_cnt++;
        repeat (17) @(negedge clk);

        tick_gap();
        tick_gap();
        close_window();
        check_cnt++; if (rate_valid !== 1'b1) $display("FAIL empty_valid: got %b expected 1", rate_valid); else pass_cnt++;
        check_cnt++; if (rate !== 4'd0) $display("FAIL empty_rate: got %0d expected 0", rate); else pass_cnt++;
        repeat (18) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        tick_gap();
        tick_gap();
        car(6, 6);
        car_in = 1'b1;
        repeat (6) @(negedge clk);
        clk_1s = 1'b1;
        @(negedge clk);
        clk_1s = 1'b0;
        @(negedge clk);
        check_cnt++; if (rate_valid !== 1'b1) $display("FAIL tick_car_valid: got %b expected 1", rate_valid); else pass_cnt++;
        check_cnt++; if (rate !== 4'd2) $display("FAIL tick_car_rate: got %0d expected 2", rate); else pass_cnt++;
        car_in = 1'b0;
        repeat (10) @(negedge clk);

        tick_gap();
        tick_gap();
        car(6, 6);
        car_in = 1'b1;
        repeat (5) @(negedge clk);
        clk_1s = 1'b1;
        @(negedge clk);
        clk_1s = 1'b0;
        check_cnt++; if (car_pulse !== 1'b1) $display("FAIL close_car_pulse: got %b expected 1", car_pulse); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (rate_valid !== 1'b1) $display("FAIL close_car_valid: got %b expected 1", rate_valid); else pass_cnt++;
        check_cnt++; if (rate !== 4'd1) $display("FAIL close_car_rate: got %0d expected 1", rate); else pass_cnt++;
        car_in = 1'b0;
        repeat (10) @(negedge clk);

        tick_gap();
        tick_gap();
        close_window();
        check_cnt++; if (rate !== 4'd1) $display("FAIL close_car_next_rate: got %0d expected 1", rate); else pass_cnt++;
        repeat (18) @(negedge clk);
    endtask

    task automatic test_saturation();
        repeat (20) car(6, 6);
        tick_gap();
        tick_gap();
        close_window();
        check_cnt++; if (rate_valid !== 1'b1) $display("FAIL sat_valid: got %b expected 1", rate_valid); else pass_cnt++;
        check_cnt++; if (rate !== 4'd15) $display("FAIL sat_rate: got %0d expected 15", rate); else pass_cnt++;
        repeat (18) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int valids;
        valids = 0;
        tick_gap();
        tick_gap();
        repeat (3) car(6, 6);
        check_cnt++; if (sec_cnt !== 8'd2) $display("FAIL mid_sec_before: got %0d expected 2", sec_cnt); else pass_cnt++;
        rst    = 1'b1;
        clk_1s = 1'b1;
        clr    = 1'b1;
        @(negedge clk);
        clk_1s = 1'b0;
        clr    = 1'b0;
        check_cnt++; if (rate_valid !== 1'b0) $display("FAIL mid_valid: got %b expected 0", rate_valid); else pass_cnt++;
        check_cnt++; if (rate !== 4'd0) $display("FAIL mid_rate: got %0d expected 0", rate); else pass_cnt++;
        check_cnt++; if (sec_cnt !== 8'd0) $display("FAIL mid_sec: got %0d expected 0", sec_cnt); else pass_cnt++;
        check_cnt++; if (total_bcd !== 16'h0000) $display("FAIL mid_total: got %h expected 0000", total_bcd); else pass_cnt++;
        check_cnt++; if (car_pulse !== 1'b0) $display("FAIL mid_car_pulse: got %b expected 0", car_pulse); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rate_valid === 1'b1) valids++;
        end
        check_cnt++; if (valids !== 0) $display("FAIL mid_no_valid: got %0d expected 0", valids); else pass_cnt++;
        tick_gap();
        tick_gap();
        close_window();
        check_cnt++; if (rate_valid !== 1'b1) $display("FAIL mid_next_valid: got %b expected 1", rate_valid); else pass_cnt++;
        check_cnt++; if (rate !== 4'd0) $display("FAIL mid_next_rate: got %0d expected 0", rate); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_clean_car();
        test_bounce();
        test_clr_collision();
        test_bcd_wrap();
        test_window();
        test_simultaneous();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, check_cnt);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/car_flow_counter.md
# car_flow_counter

Downstream consumer of the 1 s tick generator in the car-count design. Debounces a raw car-presence sensor and emits one pulse per car. Keeps a 4-digit BCD running total. Once per measurement window (a fixed number of 1 s ticks) it latches the number of cars counted in that window as a flow rate.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: clk cycles the synchronized sensor must differ from the debounced level before the change is accepted (20 ms at 50 MHz). Legal values ≥ 2.
- WINDOW_S, 60: measurement window length in 1 s ticks. Legal range 1–255.
- RATE_W, 8: width of the per-window car count.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- clk_1s  in  1  one-clk-cycle pulse, once per second, from the tick generator.
- car_in  in  1  raw sensor, active high while a car is present. Asynchronous to clk; bounces.
- clr  in  1  synchronous clear of total_bcd only.
- car_pulse  out  1  one-cycle pulse per accepted car (rising edge of the debounced level).
- total_bcd  out  16  running total as 4 BCD digits, [15:12] = thousands.
- sec_cnt  out  8  ticks elapsed in the current window, 0..WINDOW_S-1.
- rate  out  RATE_W  cars counted in the last completed window.
- rate_valid  out  1  one-cycle pulse when rate is updated.

## Operation
- Synchronizer: two flops on car_in (s1, s2). Every other stage uses only s2.
- Debounce: registers car_db (debounced level) and db_cnt (ceil(log2(DEBOUNCE_CYCLES)) bits).
  - s2 == car_db: db_cnt <= 0.
  - s2 != car_db and db_cnt < DEBOUNCE_CYCLES-1: db_cnt increments.
  - s2 != car_db and db_cnt == DEBOUNCE_CYCLES-1: car_db <= s2 and db_cnt <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is discarded.
- car_pulse is registered. It is set on the same edge car_db changes 0→1; in every other cycle it is 0. A falling accept produces no pulse.
- Total counter, per edge, in priority order:
  - clr: total_bcd <= 0. A car_pulse in the same cycle is dropped.
  - car_pulse: BCD increment. A digit at 9 carries to the next digit. 9999 wraps to 0000.
- Window state machine (two states: COUNT, CLOSE):
  - COUNT:
    - car_pulse increments win_cnt, saturating at 2^RATE_W-1.
    - clk_1s with sec_cnt < WINDOW_S-1 increments sec_cnt.
    - clk_1s with sec_cnt == WINDOW_S-1 moves to CLOSE.
  - CLOSE (exactly one cycle):
    - rate <= win_cnt; rate_valid = 1; win_cnt <= 0 (or 1 if car_pulse is high this cycle); sec_cnt <= 0; return to COUNT.
  - A car_pulse in the cycle of the closing tick is counted in the closing window.
  - A car_pulse during CLOSE belongs to the new window.
  - clk_1s cannot occur in CLOSE: the tick period is more than 2 cycles.
- clr does not affect sec_cnt, win_cnt, rate or the window state.

## Timing
- Reset values (all synchronous on rst):
  - s1, s2, car_db, db_cnt, car_pulse = 0.
  - total_bcd = 16'h0000; sec_cnt = 0; win_cnt = 0; rate = 0; rate_valid = 0; state = COUNT.
- rst mid-window: the partial window is discarded and no rate_valid is emitted. rst overrides clr and every other input.
- Sensor latency, with car_in high before edge k and held stable (D = DEBOUNCE_CYCLES):
  - s2 = 1 after edge k+1.
  - car_db = 1 and car_pulse = 1 after edge k+D+1.
  - total_bcd is updated after edge k+D+2.
- Window latency: for the closing tick sampled at edge t, the state is CLOSE after t. rate and rate_valid are then registered at edge t+1, so they are visible after edge t+1 and rate_valid is high for that one cycle.
- Minimum car spacing for each car to be counted: a high period of D cycles plus a low period of D cycles.

## Test plan
Test parameters: DEBOUNCE_CYCLES=4, WINDOW_S=3, RATE_W=4. The clk_1s period is 20 cycles.
- Reset and clean car: after rst, all outputs are 0. car_in is raised at edge k and held 10 cycles → exactly one car_pulse, after edge k+5. total_bcd = 0001 after edge k+6.
- Bounce rejection: car_in toggles 1,0,1,0 every cycle, then holds high 8 cycles → one car_pulse only. A single 3-cycle high glitch produces no pulse.
- BCD carry and wrap:
  - Preload via 99 clean cars → 0099; the next car → 0100.
  - Continue to 9999; the next car → 0000.
  - clr asserted in the same cycle as car_pulse → 0000, and the car is not counted.
- Window rate:
  - 5 cars within 3 ticks → rate = 5 and one rate_valid pulse, one cycle after the 3rd tick; sec_cnt returns to 0.
  - The next empty window → rate = 0.
- Simultaneous events:
  - car_pulse in the cycle of the closing tick → counted in the closing window (rate includes it).
  - car_pulse in the CLOSE cycle → counted in the next window.
- Saturation and reset mid-operation:
  - 20 cars in one window → rate = 15.
  - rst asserted with sec_cnt = 2 and win_cnt = 3 → no rate_valid; all registers at their reset values after that edge.
